pipeline_stage_skid: RTL and testbench

- Parametrised successor to the fixed 32-bit IF/ID register.
- Registered pipeline stage carrying a data word and PC, with a valid/ready handshake upstream and a valid flag downstream.
- Adds a SKID_DEPTH-entry FIFO so items arriving during Stall are kept and replayed in order, not dropped or re-fetched.
- Flush inserts a bubble of NOP_WORD; a saturating counter reports stall cycles for performance monitoring.

---
 rtl/pipeline_stage_skid_if.sv | 40 ++++
 rtl/pipeline_stage_skid.sv | 167 ++++++++++++++++
 tb/tb_pipeline_stage_skid.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipeline_stage_skid_if
//   Bundles the upstream valid/ready handshake and the downstream registered
//   item of one pipeline stage.
//
//   Signals
//     In_valid  upstream item present
//     In_ready  stage can accept this cycle
//     In_data   upstream word            (DATA_W)
//     In_pc     upstream PC              (PC_W)
//     Out_valid Out_data/Out_pc hold a real item
//     Out_data  registered word          (DATA_W)
//     Out_pc    registered PC            (PC_W)
//
//   Modports
//     slave   the stage itself: consumes In_*, produces In_ready and Out_*
//     master  the surrounding pipeline: produces In_*, observes the rest
// ---------------------------------------------------------------------------
interface pipeline_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              In_valid;
  logic              In_ready;
  logic [DATA_W-1:0] In_data;
  logic [PC_W-1:0]   In_pc;
  logic              Out_valid;
  logic [DATA_W-1:0] Out_data;
  logic [PC_W-1:0]   Out_pc;

  modport slave (
    input  In_valid, In_data, In_pc,
    output In_ready, Out_valid, Out_data, Out_pc
  );

  modport master (
    output In_valid, In_data, In_pc,
    input  In_ready, Out_valid, Out_data, Out_pc
  );
endinterface

// File: rtl/pipeline_stage_skid.sv
// ---------------------------------------------------------------------------
// pipeline_stage_skid
//   Registered pipeline stage (word + PC) with a small skid FIFO. Items that
//   arrive while the stage is stalled are queued and replayed in order once
//   the stall lifts. Flush squashes the stage and the skid and inserts a
//   NOP_WORD bubble. A saturating counter reports cycles spent stalled while
//   holding a real item.
//
//   Ports
//     Clk           rising-edge clock
//     Reset         asynchronous, active-high reset
//     bus           pipeline_stage_skid_if.slave (In_* handshake, Out_* item)
//     Stall         hold the outputs; accepted items go to the skid
//     Flush         squash stage and skid (wins over Stall)
//     Skid_count    current skid occupancy, 0..SKID_DEPTH
//     Stall_cycles  saturating stall-cycle counter, cleared only by Reset
// ---------------------------------------------------------------------------
module pipeline_stage_skid #(
  parameter int                DATA_W     = 32,
  parameter int                PC_W       = 32,
  parameter int                SKID_DEPTH = 2,   // 1..4
  parameter logic [DATA_W-1:0] NOP_WORD   = '0,
  parameter int                CNT_W      = 16,
  localparam int               SC_W       = $clog2(SKID_DEPTH + 1)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pipeline_stage_skid_if.slave bus,
  input  logic                 Stall,
  input  logic                 Flush,
  output logic [SC_W-1:0]      Skid_count,
  output logic [CNT_W-1:0]     Stall_cycles
);

  localparam int              PTR_W   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [SC_W-1:0] DEPTH_C = SC_W'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(SKID_DEPTH - 1);

  // Per-cycle operating mode, decoded once so the priority lives in one place.
  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH
  } mode_e;

  mode_e             mode;
  logic              in_ready;
  logic              accept;
  logic              skid_empty;
  logic              push;
  logic              pop;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] skid_data [SKID_DEPTH];
  logic [PC_W-1:0]   skid_pc   [SKID_DEPTH];

  // Depth need not be a power of two, so wrap with an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the branches can leave one unassigned and infer a latch.
  always_comb begin
    mode       = MODE_RUN;
    in_ready   = 1'b0;
    accept     = 1'b0;
    skid_empty = (Skid_count == '0);
    push       = 1'b0;
    pop        = 1'b0;

    if (Flush)      mode = MODE_FLUSH;
    else if (Stall) mode = MODE_STALL;

    in_ready = !Flush && (Skid_count < DEPTH_C);
    accept   = bus.In_valid && in_ready;

    // While stalled, or while older items are still queued, an accepted item
    // must go through the skid to keep strict FIFO order. Only an idle skid
    // in a running cycle lets the input bypass straight to the output.
    unique case (mode)
      MODE_STALL: push = accept;
      MODE_RUN: begin
        pop  = !skid_empty;
        push = accept && !skid_empty;
      end
      default: ;
    endcase
  end

  assign bus.In_ready = in_ready;

  // NOTE: the skid storage has no reset; occupancy is tracked by the
  // count/pointers, so stale entries are never read and resetting the array
  // would only add reset fan-out to plain storage.
  always_ff @(posedge Clk) begin
    if (push) begin
      skid_data[wr_ptr] <= bus.In_data;
      skid_pc[wr_ptr]   <= bus.In_pc;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Skid_count <= '0;
    end else if (mode == MODE_FLUSH) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Skid_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      // Push and pop together leave the occupancy unchanged.
      if (push && !pop)      Skid_count <= Skid_count + SC_W'(1);
      else if (pop && !push) Skid_count <= Skid_count - SC_W'(1);
    end
  end

  // Output register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.Out_valid <= 1'b0;
      bus.Out_data  <= NOP_WORD;
      bus.Out_pc    <= '0;
    end else begin
      unique case (mode)
        MODE_FLUSH: begin
          bus.Out_valid <= 1'b0;
          bus.Out_data  <= NOP_WORD;
          bus.Out_pc    <= bus.In_pc;
        end
        MODE_STALL: ; // hold
        MODE_RUN: begin
          if (!skid_empty) begin
            bus.Out_valid <= 1'b1;
            bus.Out_data  <= skid_data[rd_ptr];
            bus.Out_pc    <= skid_pc[rd_ptr];
          end else if (accept) begin
            bus.Out_valid <= 1'b1;
            bus.Out_data  <= bus.In_data;
            bus.Out_pc    <= bus.In_pc;
          end else begin
            // Bubble: PC is left as-is, only the word is squashed.
            bus.Out_valid <= 1'b0;
            bus.Out_data  <= NOP_WORD;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall cycles are only counted while a real item is being held.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Stall_cycles <= '0;
    end else if (mode == MODE_STALL && bus.Out_valid && (Stall_cycles != '1)) begin
      Stall_cycles <= Stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_skid
//   Two instances: dut_a (SKID_DEPTH=2, CNT_W=4) and dut_b (SKID_DEPTH=3,
//   CNT_W=16). One shared stimulus set is steered to the selected instance;
//   a queue of accepted items plus a few expected registers predict every
//   output after each clock edge.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_skid;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } item_t;

  logic        Clk;
  logic        Reset;
  logic        sel;        // 0: dut_a, 1: dut_b
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        stall;
  logic        flush;

  logic [1:0]  a_skid;
  logic [3:0]  a_cnt;
  logic [1:0]  b_skid;
  logic [15:0] b_cnt;

  pipeline_stage_skid_if #(.DATA_W(32), .PC_W(32)) if_a ();
  pipeline_stage_skid_if #(.DATA_W(32), .PC_W(32)) if_b ();

  assign if_a.In_valid = !sel && in_valid;
  assign if_a.In_data  = in_data;
  assign if_a.In_pc    = in_pc;
  assign if_b.In_valid = sel && in_valid;
  assign if_b.In_data  = in_data;
  assign if_b.In_pc    = in_pc;

  pipeline_stage_skid #(
    .DATA_W(32), .PC_W(32), .SKID_DEPTH(2), .NOP_WORD(NOP), .CNT_W(4)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(if_a.slave),
    .Stall(!sel && stall), .Flush(!sel && flush),
    .Skid_count(a_skid), .Stall_cycles(a_cnt)
  );

  pipeline_stage_skid #(
    .DATA_W(32), .PC_W(32), .SKID_DEPTH(3), .NOP_WORD(NOP), .CNT_W(16)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(if_b.slave),
    .Stall(sel && stall), .Flush(sel && flush),
    .Skid_count(b_skid), .Stall_cycles(b_cnt)
  );

  // Observed values of the selected instance.
  logic        obs_ready, obs_valid;
  logic [31:0] obs_data, obs_pc;
  logic [1:0]  obs_skid;
  logic [15:0] obs_cnt;

  assign obs_ready = sel ? if_b.In_ready  : if_a.In_ready;
  assign obs_valid = sel ? if_b.Out_valid : if_a.Out_valid;
  assign obs_data  = sel ? if_b.Out_data  : if_a.Out_data;
  assign obs_pc    = sel ? if_b.Out_pc    : if_a.Out_pc;
  assign obs_skid  = sel ? b_skid         : a_skid;
  assign obs_cnt   = sel ? b_cnt          : {12'h0, a_cnt};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard and expected output registers.
  item_t       q[$];
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [31:0] exp_pc;
  int          exp_cnt;
  logic        last_acc;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depth();
    return sel ? 3 : 2;
  endfunction

  function automatic int cnt_max();
    return sel ? 65535 : 15;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_valid = 1'b0;
    exp_data  = NOP;
    exp_pc    = '0;
    exp_cnt   = 0;
    last_acc  = 1'b0;
  endtask

  task automatic compare_out(input string ctx);
    check({ctx, ".out_valid"},  obs_valid, exp_valid);
    check({ctx, ".out_data"},   obs_data,  exp_data);
    check({ctx, ".out_pc"},     obs_pc,    exp_pc);
    check({ctx, ".skid_count"}, obs_skid,  q.size());
    check({ctx, ".stall_cyc"},  obs_cnt,   exp_cnt);
  endtask

  // One clock: drive inputs, check In_ready, clock, update model, compare.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [31:0] p,
                       input logic st, input logic fl, input string ctx);
    logic  m_ready;
    logic  acc;
    item_t it;
    in_valid = v;
    in_data  = d;
    in_pc    = p;
    stall    = st;
    flush    = fl;
    #1;
    m_ready = !fl && (q.size() < depth());
    check({ctx, ".in_ready"}, obs_ready, m_ready);
    acc = v && m_ready;
    @(posedge Clk);
    if (fl) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = NOP;
      exp_pc    = p;
    end else if (st) begin
      if (exp_valid && exp_cnt < cnt_max()) exp_cnt++;
      if (acc) q.push_back('{data: d, pc: p});
    end else begin
      if (acc) q.push_back('{data: d, pc: p});
      if (q.size() > 0) begin
        it        = q.pop_front();
        exp_valid = 1'b1;
        exp_data  = it.data;
        exp_pc    = it.pc;
      end else begin
        exp_valid = 1'b0;
        exp_data  = NOP;
      end
    end
    last_acc = acc;
    #1;
    compare_out(ctx);
  endtask

  // Upstream source: presents item k until accepted. pct=0 uses stall_vec,
  // pct>0 draws random stalls (pct %) and random valid gaps.
  task automatic stream(input int base, input int n, input int ncyc,
                        input logic [63:0] stall_vec, input int pct, input string ctx);
    int   k    = 0;
    logic hold = 1'b0;
    logic v, st;
    for (int c = 0; c < ncyc; c++) begin
      if (pct > 0) begin
        st = ($urandom_range(0, 99) < pct);
        v  = (k < n) && (hold || ($urandom_range(0, 99) < 70));
      end else begin
        st = stall_vec[c];
        v  = (k < n);
      end
      cycle(v, 32'(base + k), 32'(k * 4), st, 1'b0, ctx);
      if (last_acc) k++;
      hold = v && !last_acc;
    end
  endtask

  task automatic do_reset(input logic s);
    @(posedge Clk);
    #2;
    in_valid = 1'b0;
    in_data  = '0;
    in_pc    = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    Reset    = 1'b1;
    sel      = s;
    model_reset();
    #1;
    compare_out("reset");
    #4;
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    sel      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_pc    = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    model_reset();

    // Plain streaming, no stall.
    do_reset(1'b0);
    stream(32'hA0, 4, 6, 64'h0, 0, "stream_a");

    // Stall for 3 cycles while B1 is held; skid fills to 2.
    do_reset(1'b0);
    stream(32'hB0, 6, 10, 64'h1C, 0, "stall_b");
    check("stall_b.total_stall", obs_cnt, 16'd3);

    // Fill skid, then Flush with Stall together.
    do_reset(1'b0);
    cycle(1'b1, 32'hC0, 32'h00, 1'b0, 1'b0, "flush_fill");
    cycle(1'b1, 32'hC1, 32'h04, 1'b1, 1'b0, "flush_fill");
    cycle(1'b1, 32'hC2, 32'h08, 1'b1, 1'b0, "flush_fill");
    check("flush.skid_full", obs_skid, 2'd2);
    cycle(1'b1, 32'hC3, 32'h40, 1'b1, 1'b1, "flush");
    check("flush.pc", obs_pc, 32'h40);
    check("flush.valid", obs_valid, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "after_flush");

    // Counter saturation with a 4-bit counter.
    do_reset(1'b0);
    cycle(1'b1, 32'hD0, 32'h00, 1'b0, 1'b0, "sat_load");
    repeat (20) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "sat");
    check("sat.stall_cycles", obs_cnt, 16'd15);

    // Asynchronous reset mid-stall with a full skid.
    do_reset(1'b0);
    cycle(1'b1, 32'hE0, 32'h00, 1'b0, 1'b0, "areset_fill");
    cycle(1'b1, 32'hE1, 32'h04, 1'b1, 1'b0, "areset_fill");
    cycle(1'b1, 32'hE2, 32'h08, 1'b1, 1'b0, "areset_fill");
    in_valid = 1'b1;
    stall    = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    check("areset.out_valid",  obs_valid, 1'b0);
    check("areset.out_data",   obs_data,  NOP);
    check("areset.out_pc",     obs_pc,    32'h0);
    check("areset.skid_count", obs_skid,  2'd0);
    check("areset.stall_cyc",  obs_cnt,   16'd0);
    model_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "after_areset");

    // Depth 3: random interleave of stalls and gaps, then drain.
    do_reset(1'b1);
    stream(32'h100, 10, 60, 64'h0, 40, "wrap_b");
    repeat (6) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "wrap_drain");
    check("wrap.drained", obs_skid, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
